// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the global-history branch predictor.
package branch_predictor_pkg;

  localparam int PATTERN_WIDTH  = 4;
  localparam int INST_MEM_WIDTH = 16;

  localparam logic [1:0] PHT_INIT = 2'b01;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } bp_state_t;

  typedef struct packed {
    logic                     pred;
    logic [PATTERN_WIDTH-1:0] index;
  } bp_fifo_entry;

  // 2-bit saturating counter step toward taken (11) or not-taken (00).
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != 2'b11) res = cnt + 2'b01;
    else if (!taken && cnt != 2'b00) res = cnt - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit counters, one combinational read port, one write port
// that either loads the init value or applies a saturating update.
module bp_pht #(
  parameter int PATTERN_WIDTH = branch_predictor_pkg::PATTERN_WIDTH
) (
  input  logic                     clk,
  input  logic [PATTERN_WIDTH-1:0] rd_index,
  output logic [1:0]               rd_counter,
  input  logic                     wr_en,
  input  logic [PATTERN_WIDTH-1:0] wr_index,
  input  logic                     wr_init,
  input  logic                     wr_taken
);
  import branch_predictor_pkg::*;

  // No reset: the INIT sweep fills every entry before the table is consulted.
  logic [1:0] counters [2**PATTERN_WIDTH];

  assign rd_counter = counters[rd_index];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      counters[wr_index] <= wr_init ? PHT_INIT : sat_update(counters[wr_index], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Global-history branch predictor with misprediction flush sequencing.
// Optional build macro BP_GSHARE_EN: index the PHT with GHR ^ pc instead of GHR alone.
module branch_predictor #(
  parameter int PATTERN_WIDTH  = branch_predictor_pkg::PATTERN_WIDTH,
  parameter int N_INFLIGHT     = 4,
  parameter int INST_MEM_WIDTH = branch_predictor_pkg::INST_MEM_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] target,
  output logic                      prediction,
  output logic [PATTERN_WIDTH-1:0]  pattern_out,
  output logic [INST_MEM_WIDTH-1:0] addr_on_failure_out,
  input  logic                      commit,
  input  logic                      failure,
  input  logic [PATTERN_WIDTH-1:0]  pattern_in,
  input  logic [INST_MEM_WIDTH-1:0] addr_on_failure_in,
  output logic                      flush,
  output logic [INST_MEM_WIDTH-1:0] redirect_addr,
  output logic                      busy
);
  import branch_predictor_pkg::*;

  localparam int PHT_SIZE = 2**PATTERN_WIDTH;
  localparam int PTR_W    = (N_INFLIGHT > 1) ? $clog2(N_INFLIGHT) : 1;
  localparam int CNT_W    = $clog2(N_INFLIGHT + 1);

  bp_state_t                 state_reg, state_next;
  logic [PATTERN_WIDTH-1:0]  ghr_reg;
  logic [PATTERN_WIDTH-1:0]  sweep_reg;
  logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]          count_reg;
  bp_fifo_entry              fifo_mem [N_INFLIGHT];

  logic [PATTERN_WIDTH-1:0]  issue_index;
  logic [1:0]                pht_counter;
  logic                      fifo_full, fifo_empty;
  logic                      commit_ok, mispredict, actual, push;
  bp_fifo_entry              head;
  logic                      pht_wr_en, pht_wr_init;
  logic [PATTERN_WIDTH-1:0]  pht_wr_index;
  logic                      unused_pattern_msb;

`ifdef BP_GSHARE_EN
  assign issue_index = ghr_reg ^ pc[PATTERN_WIDTH-1:0];
`else
  assign issue_index = ghr_reg;
`endif

  assign prediction          = pht_counter[1];
  assign pattern_out         = ghr_reg;
  assign addr_on_failure_out = prediction ? pc + INST_MEM_WIDTH'(1) : target;

  assign fifo_full  = (count_reg == CNT_W'(N_INFLIGHT));
  assign fifo_empty = (count_reg == '0);
  assign head       = fifo_mem[rd_ptr_reg];
  assign actual     = head.pred ^ failure;
  // A commit against an empty FIFO is a protocol error and is dropped here.
  assign commit_ok  = (state_reg == RUN) && commit && !fifo_empty;
  assign mispredict = commit_ok && failure;
  assign push       = issue_valid && issue_ready && !mispredict;

  assign unused_pattern_msb = pattern_in[PATTERN_WIDTH-1];

  assign pht_wr_init  = (state_reg == INIT);
  assign pht_wr_en    = pht_wr_init || commit_ok;
  assign pht_wr_index = pht_wr_init ? sweep_reg : head.index;

  bp_pht #(.PATTERN_WIDTH(PATTERN_WIDTH)) u_pht (
    .clk       (clk),
    .rd_index  (issue_index),
    .rd_counter(pht_counter),
    .wr_en     (pht_wr_en),
    .wr_index  (pht_wr_index),
    .wr_init   (pht_wr_init),
    .wr_taken  (actual)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= INIT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      INIT:    if (sweep_reg == PATTERN_WIDTH'(PHT_SIZE - 1)) state_next = RUN;
      RUN:     if (mispredict) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    flush       = 1'b0;
    issue_ready = 1'b0;
    unique case (state_reg)
      INIT:    busy = 1'b1;
      RUN:     issue_ready = !fifo_full || commit;
      FLUSH:   flush = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_reg       <= '0;
      sweep_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      redirect_addr <= '0;
    end else begin
      sweep_reg <= (state_reg == INIT) ? sweep_reg + PATTERN_WIDTH'(1) : '0;
      if (mispredict) begin
        redirect_addr <= addr_on_failure_in;
        ghr_reg       <= {pattern_in[PATTERN_WIDTH-2:0], actual};
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        count_reg     <= '0;
      end else begin
        if (push) begin
          ghr_reg    <= {ghr_reg[PATTERN_WIDTH-2:0], prediction};
          wr_ptr_reg <= (wr_ptr_reg == PTR_W'(N_INFLIGHT - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (commit_ok) begin
          rd_ptr_reg <= (rd_ptr_reg == PTR_W'(N_INFLIGHT - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        unique case ({push, commit_ok})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= '{pred: prediction, index: issue_index};
  end

endmodule
